capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold time in clk cycles that classifies a press as long (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter CNT_W, default 26, width of the press-duration counter; SHALL satisfy 2^CNT_W > LONG_CYCLES.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_db  input  1  debounced capture-button level, 1 = pressed.
REQ-006 vsync  input  1  camera frame-start strobe, one clk cycle wide.
REQ-007 cfg_done  input  1  camera-configuration complete strobe, one clk cycle wide.
REQ-008 cfg_start  output  1  one-cycle request to (re)configure the camera.
REQ-009 wr_en  output  1  frame-buffer write enable.
REQ-010 frozen  output  1  high while a captured frame is being held.
REQ-011 busy  output  1  high while configuration is pending.
REQ-012 frame_cnt  output  8  count of frame starts seen while writing, wraps 255->0.

Function
REQ-013 Press classifier: counter increments each cycle btn_db=1, saturates at LONG_CYCLES, clears to 0 the cycle after btn_db=0.
REQ-014 long_evt SHALL pulse exactly once per press, in the cycle the counter goes from LONG_CYCLES-1 to LONG_CYCLES, while btn_db is still high.
REQ-015 short_evt SHALL pulse one cycle after btn_db falls, only if long_evt did not fire during that press.
REQ-016 FSM states: CFG_START, CFG_WAIT, RUN_PEND, LIVE, STOP_PEND, FROZEN.
REQ-017 CFG_START: cfg_start=1, busy=1; go to CFG_WAIT unconditionally next cycle.
REQ-018 CFG_WAIT: busy=1; on cfg_done go to RUN_PEND; all press events are ignored.
REQ-019 RUN_PEND: wr_en=0; on vsync go to LIVE.
REQ-020 LIVE: wr_en=1; short_evt -> STOP_PEND; long_evt -> CFG_START.
REQ-021 STOP_PEND: wr_en=1 (finishes the current frame); vsync -> FROZEN; long_evt -> CFG_START; short_evt ignored.
REQ-022 FROZEN: wr_en=0, frozen=1; short_evt -> RUN_PEND; long_evt -> CFG_START.
REQ-023 Priority in any state: long_evt > vsync > short_evt; a lower-priority event in the same cycle is dropped, not queued.
REQ-024 All outputs are registered or Moore-decoded from state; each transition takes effect in the cycle after the triggering input.
REQ-025 frame_cnt increments on each vsync received in LIVE or STOP_PEND, including the vsync that leaves STOP_PEND; 8-bit modulo wrap.
REQ-026 A vsync and cfg_done arriving together in CFG_WAIT: cfg_done is taken; that vsync is not used to leave RUN_PEND.

Reset
REQ-027 On reset=1 at a clk edge: state=CFG_START, press counter=0, long-fired flag=0, frame_cnt=0.
REQ-028 During and after reset, until the first transition: cfg_start=1, busy=1, wr_en=0, frozen=0, frame_cnt=0.
REQ-029 Reset mid-press: the press is discarded; no short_evt on the following release.

Structure
REQ-030 FSM state encoding and the default LONG_CYCLES value SHALL live in the shared package cam_ctrl_pkg.
REQ-031 Press classification SHALL be a sub-module press_classifier (inputs clk, reset, btn_db; outputs short_evt, long_evt), instantiated once.

Verification (LONG_CYCLES=8)
REQ-032 Reset, cfg_done at cycle 5, vsync at cycle 10 -> cfg_start high only for the first cycle after reset; wr_en rises at cycle 11; frame_cnt=0.
REQ-033 In LIVE, btn_db high 3 cycles, then vsync -> short_evt 1 cycle after release; wr_en stays 1 until vsync, then 0; frozen=1; frame_cnt increments by 1.
REQ-034 In FROZEN, btn_db held 20 cycles -> exactly one long_evt at the 8th held cycle; one cfg_start pulse; no short_evt on release.
REQ-035 In STOP_PEND, vsync and long_evt in the same cycle -> next state CFG_START; frozen never asserts; frame_cnt increments only as REQ-025 specifies.
REQ-036 Writing with 256 vsyncs -> frame_cnt reads 0 after the 256th; reset asserted mid-press in LIVE -> all REQ-028 values, no events on release.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the camera capture controller.
package cam_ctrl_pkg;

    // Hold time that classifies a press as long: 1 s at 50 MHz.
    localparam int unsigned LongCyclesDefault = 32'd50_000_000;
    localparam int unsigned CntWDefault       = 32'd26;

    typedef enum logic [2:0] {
        StCfgStart = 3'd0,
        StCfgWait  = 3'd1,
        StRunPend  = 3'd2,
        StLive     = 3'd3,
        StStopPend = 3'd4,
        StFrozen   = 3'd5
    } cam_state_e;

endpackage

// File: rtl/press_classifier.sv
// Classifies button presses into one-cycle short and long events.
module press_classifier
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LongCyclesDefault,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_db,
    output logic short_evt,
    output logic long_evt
);

    logic [CNT_W-1:0] cnt_q;
    logic             long_fired_q;
    logic             short_q;
    // Set when the button was already down at reset, so that press is never classified.
    logic             discard_q;

    // Long event fires in the cycle the counter steps from LONG_CYCLES-1 to LONG_CYCLES.
    always_comb begin
        long_evt  = btn_db && !discard_q && (cnt_q == CNT_W'(LONG_CYCLES - 1));
        short_evt = short_q;
    end

    // Press-duration counter, long-fired flag and registered short event.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            long_fired_q <= 1'b0;
            short_q      <= 1'b0;
            discard_q    <= btn_db;
        end else begin
            // Non-zero count on the first low cycle means a press just ended.
            short_q <= !btn_db && (cnt_q != '0) && !long_fired_q;
            if (!btn_db) begin
                cnt_q        <= '0;
                long_fired_q <= 1'b0;
                discard_q    <= 1'b0;
            end else if (!discard_q) begin
                if (cnt_q != CNT_W'(LONG_CYCLES)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (long_evt) begin
                    long_fired_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Camera capture controller: configure, stream, freeze and resume on button presses.
module capture_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LongCyclesDefault,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_db,
    input  logic       vsync,
    input  logic       cfg_done,
    output logic       cfg_start,
    output logic       wr_en,
    output logic       frozen,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    cam_state_e state_q, state_d;
    logic       short_evt;
    logic       long_evt;
    logic [7:0] frame_cnt_q;

    press_classifier #(
        .LONG_CYCLES (LONG_CYCLES),
        .CNT_W       (CNT_W)
    ) u_press (
        .clk       (clk),
        .reset     (reset),
        .btn_db    (btn_db),
        .short_evt (short_evt),
        .long_evt  (long_evt)
    );

    // Next-state selection (long > vsync > short) and Moore output decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCfgStart: state_d = StCfgWait;
            StCfgWait:  if (cfg_done) state_d = StRunPend;
            StRunPend:  if (vsync) state_d = StLive;
            StLive: begin
                if (long_evt)             state_d = StCfgStart;
                else if (!vsync && short_evt) state_d = StStopPend;
            end
            StStopPend: begin
                if (long_evt)   state_d = StCfgStart;
                else if (vsync) state_d = StFrozen;
            end
            StFrozen: begin
                if (long_evt)             state_d = StCfgStart;
                else if (!vsync && short_evt) state_d = StRunPend;
            end
            default: state_d = StCfgStart;
        endcase

        cfg_start = (state_q == StCfgStart);
        busy      = (state_q == StCfgStart) || (state_q == StCfgWait);
        wr_en     = (state_q == StLive) || (state_q == StStopPend);
        frozen    = (state_q == StFrozen);
        frame_cnt = frame_cnt_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StCfgStart;
        else       state_q <= state_d;
    end

    // Frame counter: every vsync seen while writing counts, even one that a
    // simultaneous long press overrides for the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else if (vsync && wr_en) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with LONG_CYCLES = 8.
module tb_capture_ctrl;

    localparam int LC = 8;

    logic       clk = 1'b0;
    logic       reset, btn_db, vsync, cfg_done;
    logic       cfg_start, wr_en, frozen, busy;
    logic [7:0] frame_cnt;

    capture_ctrl #(
        .LONG_CYCLES (LC),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_db    (btn_db),
        .vsync     (vsync),
        .cfg_done  (cfg_done),
        .cfg_start (cfg_start),
        .wr_en     (wr_en),
        .frozen    (frozen),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 request config, 1 awaiting config, 2 armed,
    // 3 writing, 4 finishing frame, 5 holding frame.
    int m_ph, m_held, m_fc;
    bit m_taint, m_spend, m_valid;
    int cs_cnt, fr_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model_cfg_start", cfg_start, m_ph == 0);
        chk("model_busy", busy, m_ph <= 1);
        chk("model_wr_en", wr_en, (m_ph == 3) || (m_ph == 4));
        chk("model_frozen", frozen, m_ph == 5);
        chk("model_frame_cnt", frame_cnt, m_fc);
    endtask

    task automatic model_step(input bit r, input bit b, input bit v, input bit d);
        bit long_now, short_now;
        if (r) begin
            m_ph = 0; m_held = 0; m_taint = b; m_spend = 0; m_fc = 0;
            return;
        end
        long_now  = b && !m_taint && (m_held == LC - 1);
        short_now = m_spend;
        if (b) begin
            m_spend = 0;
            if (!m_taint && m_held < 1000) m_held++;
        end else begin
            m_spend = !m_taint && (m_held > 0) && (m_held < LC);
            m_held  = 0;
            m_taint = 0;
        end
        if (v && (m_ph == 3 || m_ph == 4)) m_fc = (m_fc + 1) % 256;
        case (m_ph)
            0: m_ph = 1;
            1: if (d) m_ph = 2;
            2: if (v) m_ph = 3;
            3: if (long_now) m_ph = 0; else if (!v && short_now) m_ph = 4;
            4: if (long_now) m_ph = 0; else if (v) m_ph = 5;
            5: if (long_now) m_ph = 0; else if (!v && short_now) m_ph = 2;
            default: m_ph = 0;
        endcase
    endtask

    // Apply inputs for one cycle; outputs are compared #1 after the previous edge.
    task automatic tick(input bit r, input bit b, input bit v, input bit d);
        reset = r; btn_db = b; vsync = v; cfg_done = d;
        if (m_valid) cmp_model();
        if (cfg_start === 1'b1) cs_cnt++;
        if (frozen === 1'b1) fr_cnt++;
        @(posedge clk);
        model_step(r, b, v, d);
        m_valid = 1;
        #1;
    endtask

    typedef struct {
        bit         r, b, v, d;
        bit         cs, bz, wr, fr;
        logic [7:0] fc;
    } vec_t;

    function automatic vec_t mk(bit v, bit d, bit cs, bit bz, bit wr, logic [7:0] fc);
        vec_t t;
        t.r = 0; t.b = 0; t.v = v; t.d = d;
        t.cs = cs; t.bz = bz; t.wr = wr; t.fr = 0; t.fc = fc;
        return t;
    endfunction

    vec_t vecs[13];

    initial begin
        bit rb;
        reset = 1; btn_db = 0; vsync = 0; cfg_done = 0;
        m_valid = 0; cs_cnt = 0; fr_cnt = 0;

        // Rows: expected outputs in this cycle, then inputs applied in it.
        vecs[0]  = mk(0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 4; i++) vecs[i] = mk(0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 1, 0, 0);
        for (int i = 6; i <= 9; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, 1);

        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("vec%0d_cfg_start", i), cfg_start, vecs[i].cs);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].bz);
            chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
            chk($sformatf("vec%0d_frozen", i), frozen, vecs[i].fr);
            chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, vecs[i].fc);
            tick(vecs[i].r, vecs[i].b, vecs[i].v, vecs[i].d);
        end

        // Short press in LIVE, then vsync finishes the frame and freezes.
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("stop_pend_wr_en", wr_en, 1);
        tick(0, 0, 1, 0);
        chk("freeze_wr_en", wr_en, 0);
        chk("freeze_frozen", frozen, 1);
        chk("freeze_frame_cnt", frame_cnt, 2);

        // Long hold in FROZEN: single reconfiguration request.
        cs_cnt = 0;
        for (int i = 0; i < 20; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        chk("long_cfg_pulses", cs_cnt, 1);
        chk("long_busy", busy, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 1, 0);
        chk("relive_wr_en", wr_en, 1);
        chk("relive_frame_cnt", frame_cnt, 2);

        // STOP_PEND with vsync coinciding with the long event.
        tick(0, 1, 0, 0); tick(0, 1, 0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        chk("stop2_wr_en", wr_en, 1);
        fr_cnt = 0;
        for (int k = 1; k <= LC; k++) tick(0, 1, k == LC, 0);
        chk("collide_cfg_start", cfg_start, 1);
        chk("collide_frozen", frozen, 0);
        chk("collide_frame_cnt", frame_cnt, 3);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        chk("collide_never_frozen", fr_cnt, 0);

        // Frame counter wrap after 256 frames.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 1); tick(0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            tick(0, 0, 1, 0);
            if (i == 254) chk("wrap_255", frame_cnt, 255);
            tick(0, 0, 0, 0);
        end
        chk("wrap_0", frame_cnt, 0);

        // Reset mid-press in LIVE: press must be discarded.
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("rst_cfg_start", cfg_start, 1);
        chk("rst_busy", busy, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        tick(0, 1, 0, 0);
        cs_cnt = 0;
        tick(0, 1, 0, 1); tick(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("discard_wr_en", wr_en, 1);
        chk("discard_frozen", frozen, 0);
        chk("discard_no_cfg", cs_cnt, 0);
        chk("discard_frame_cnt", frame_cnt, 1);

        // Random traffic against the model.
        rb = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rb) rb = ($urandom_range(0, 5) != 0);
            else    rb = ($urandom_range(0, 3) == 0);
            tick($urandom_range(0, 599) == 0, rb, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0);
        end
        cmp_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
